restoring_divider: RTL and testbench

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/restoring_divider.sv | 108 ++++++++++
 tb/tb_restoring_divider.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider.sv
// Restoring divider: one quotient bit per clock, dividend MSB first.
// Valid/ready on both sides. All outputs come straight from registers.
// A zero divisor skips the iteration and reports div_by_zero.
module restoring_divider #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // The counter has to be wide enough to hold the value DIVIDEND_W itself.
    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    logic [1:0]            state;
    logic [CNT_W-1:0]      count;
    // The dividend bits are shifted out from the top of this register.
    // Quotient bits are shifted in at the bottom.
    logic [DIVIDEND_W-1:0] shreg;
    // The partial remainder always stays below the divisor, so DIVISOR_W bits are enough to store it.
    logic [DIVISOR_W-1:0]  prem;
    logic [DIVISOR_W-1:0]  dsr;

    // Signals for one restoring step.
    // trial is the (DIVISOR_W+1)-bit partial remainder.
    logic [DIVISOR_W:0]    trial;
    logic                  q_bit;
    logic [DIVISOR_W-1:0]  prem_next;
    logic [DIVIDEND_W-1:0] shreg_next;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // One restoring step: shift in the next dividend bit, then subtract the divisor if it fits.
    always_comb begin
        trial      = {prem, shreg[DIVIDEND_W-1]};
        q_bit      = (trial >= {1'b0, dsr});
        // If the subtraction happens, the result is below dsr, so the low DIVISOR_W bits are exact.
        prem_next  = q_bit ? (trial[DIVISOR_W-1:0] - dsr) : trial[DIVISOR_W-1:0];
        shreg_next = {shreg[DIVIDEND_W-2:0], q_bit};
    end

    // Handshake FSM, iteration registers and the result registers.
    // The result registers change only when DONE is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            shreg       <= '0;
            prem        <= '0;
            dsr         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg <= dividend;
                        dsr   <= divisor;
                        prem  <= '0;
                        if (divisor == '0) begin
                            count       <= '0;
                            quotient    <= '1;
                            remainder   <= '0;
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end else begin
                            count <= CNT_W'(DIVIDEND_W);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    shreg <= shreg_next;
                    prem  <= prem_next;
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        quotient    <= shreg_next;
                        remainder   <= prem_next;
                        div_by_zero <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed testbench for restoring_divider (16/8 defaults).
// Inputs are driven 1 time unit after posedge.
// Outputs are sampled 1 time unit after posedge or at negedge.
module tb_restoring_divider;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int compared   = 0;
    int mismatched = 0;

    restoring_divider #(.DIVIDEND_W(16), .DIVISOR_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present an operand pair. The next posedge is the acceptance edge.
    // The task returns 1 unit after that edge.
    task automatic accept(input logic [15:0] a, input logic [7:0] b);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count the edges after the acceptance edge until out_valid is seen high.
    // The count is -1 if out_valid never rises within the bound.
    task automatic wait_valid(output int edges);
        edges = 0;
        while (!out_valid && edges < 60) begin
            @(posedge clk);
            #1;
            edges++;
        end
        if (!out_valid) edges = -1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
        #3;
        compared++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        compared++;
        if (quotient !== 16'd0 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_result: q=%0d r=%0d z=%b expected 0/0/0", quotient, remainder, div_by_zero);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int e;
        out_ready = 1'b1;
        accept(16'd200, 8'd7);
        wait_valid(e);
        compared++;
        if (e !== 16) begin
            mismatched++;
            $display("FAIL basic_latency: got %0d edges expected 16", e);
        end
        compared++;
        if (quotient !== 16'd28 || remainder !== 8'd4 || div_by_zero !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_result: q=%0d r=%0d z=%b expected 28/4/0", quotient, remainder, div_by_zero);
        end
        @(posedge clk);
        #1;
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_return_idle: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_extremes;
        logic [15:0] a_t [3] = '{16'hFFFF, 16'hFFFF, 16'h0000};
        logic [7:0]  b_t [3] = '{8'h01, 8'hFF, 8'h05};
        logic [15:0] q_t [3] = '{16'hFFFF, 16'd257, 16'd0};
        logic [7:0]  r_t [3] = '{8'd0, 8'd0, 8'd0};
        int e;
        for (int i = 0; i < 3; i++) begin
            out_ready = 1'b1;
            accept(a_t[i], b_t[i]);
            wait_valid(e);
            compared++;
            if (e !== 16 || quotient !== q_t[i] || remainder !== r_t[i] || div_by_zero !== 1'b0) begin
                mismatched++;
                $display("FAIL extreme_%0d: edges=%0d q=%0d r=%0d z=%b expected 16/%0d/%0d/0",
                         i, e, quotient, remainder, div_by_zero, q_t[i], r_t[i]);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_div_by_zero;
        int e;
        out_ready = 1'b0;
        accept(16'd5, 8'd0);
        wait_valid(e);
        // For divisor 0, out_valid is already high in the first cycle after the acceptance edge.
        compared++;
        if (e !== 0) begin
            mismatched++;
            $display("FAIL dbz_latency: got %0d edges expected 0", e);
        end
        compared++;
        if (quotient !== 16'hFFFF || remainder !== 8'd0 || div_by_zero !== 1'b1) begin
            mismatched++;
            $display("FAIL dbz_result: q=%0h r=%0d z=%b expected ffff/0/1", quotient, remainder, div_by_zero);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        int e;
        out_ready = 1'b0;
        accept(16'd1000, 8'd13);
        wait_valid(e);
        for (int i = 0; i < 5; i++) begin
            compared++;
            if (out_valid !== 1'b1 || quotient !== 16'd76 || remainder !== 8'd12 || div_by_zero !== 1'b0) begin
                mismatched++;
                $display("FAIL bp_hold_%0d: v=%b q=%0d r=%0d z=%b expected 1/76/12/0",
                         i, out_valid, quotient, remainder, div_by_zero);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_busy;
        int e;
        out_ready = 1'b0;
        accept(16'd300, 8'd9);
        // New operands are presented while the divider is busy. They must be ignored.
        in_valid = 1'b1; dividend = 16'd50000; divisor = 8'd3;
        @(negedge clk);
        compared++;
        if (in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL busy_in_ready: got %b expected 0", in_ready);
        end
        wait_valid(e);
        dividend = 16'd12345; divisor = 8'd77;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (e !== 16 || quotient !== 16'd33 || remainder !== 8'd3 || div_by_zero !== 1'b0) begin
            mismatched++;
            $display("FAIL busy_result: edges=%0d q=%0d r=%0d z=%b expected 16/33/3/0",
                     e, quotient, remainder, div_by_zero);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        compared++;
        if (in_ready !== 1'b1 || quotient !== 16'd33 || remainder !== 8'd3) begin
            mismatched++;
            $display("FAIL idle_hold: in_ready=%b q=%0d r=%0d expected 1/33/3", in_ready, quotient, remainder);
        end
    endtask

    task automatic test_reset_mid_calc;
        int e;
        accept(16'd1234, 8'd3);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 16'd0) begin
            mismatched++;
            $display("FAIL rst_mid_calc: in_ready=%b out_valid=%b q=%0d expected 1/0/0", in_ready, out_valid, quotient);
        end
        repeat (2) @(posedge clk);
        #1;
        // Present operands together with reset release. The first edge must accept them.
        rst_n = 1'b1;
        accept(16'd100, 8'd10);
        wait_valid(e);
        compared++;
        if (e !== 16 || quotient !== 16'd10 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_first_accept: edges=%0d q=%0d r=%0d z=%b expected 16/10/0/0",
                     e, quotient, remainder, div_by_zero);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        int  n;
        int  e;
        logic rdy;
        logic seen_a;
        out_ready = 1'b1;
        accept(16'd40000, 8'd201);
        in_valid = 1'b1; dividend = 16'd777; divisor = 8'd25;
        n = 0;
        rdy = 1'b0;
        seen_a = 1'b0;
        while (!rdy && n < 60) begin
            @(negedge clk);
            rdy = in_ready;
            if (out_valid && !seen_a) begin
                seen_a = 1'b1;
                compared++;
                if (quotient !== 16'd199 || remainder !== 8'd1) begin
                    mismatched++;
                    $display("FAIL b2b_first: q=%0d r=%0d expected 199/1", quotient, remainder);
                end
            end
            @(posedge clk);
            n++;
            #1;
        end
        in_valid = 1'b0;
        compared++;
        if (n !== 18 || !seen_a) begin
            mismatched++;
            $display("FAIL b2b_spacing: got %0d edges (first_seen=%b) expected 18", n, seen_a);
        end
        wait_valid(e);
        compared++;
        if (e !== 16 || quotient !== 16'd31 || remainder !== 8'd2) begin
            mismatched++;
            $display("FAIL b2b_second: edges=%0d q=%0d r=%0d expected 16/31/2", e, quotient, remainder);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_random;
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] eq;
        logic [7:0]  er;
        logic        ez;
        logic        hs;
        logic        got;
        int          n;
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom_range(0, 65535));
            b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            if (b == 8'd0) begin
                eq = 16'hFFFF; er = 8'd0; ez = 1'b1;
            end else begin
                eq = a / b; er = 8'(a % b); ez = 1'b0;
            end
            accept(a, b);
            got = 1'b0;
            n = 0;
            while (!got && n < 200) begin
                out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (out_valid) begin
                    compared++;
                    if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
                        mismatched++;
                        $display("FAIL rnd_%0d %0d/%0d: q=%0d r=%0d z=%b expected %0d/%0d/%b",
                                 i, a, b, quotient, remainder, div_by_zero, eq, er, ez);
                    end
                end
                hs = out_valid && out_ready;
                @(posedge clk);
                #1;
                n++;
                if (hs) got = 1'b1;
            end
            out_ready = 1'b0;
            compared++;
            if (!got || out_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL rnd_handshake_%0d: consumed=%b out_valid_after=%b expected 1/0", i, got, out_valid);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_extremes;
        test_div_by_zero;
        test_backpressure;
        test_busy;
        test_reset_mid_calc;
        test_back_to_back;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
